// File: rtl/ro_freq_counter_pkg.sv
// Shared definitions for the ring-oscillator V/T sensor: mux select codes,
// scan FSM state encoding and RO count.
package ro_sensor_defs;

    localparam int NUM_RO = 6;

    localparam logic [2:0] SEL_IDLE = 3'b000;
    localparam logic [2:0] SEL_RO0  = 3'b111;
    localparam logic [2:0] SEL_RO1  = 3'b110;
    localparam logic [2:0] SEL_RO2  = 3'b101;
    localparam logic [2:0] SEL_RO3  = 3'b100;
    localparam logic [2:0] SEL_RO4  = 3'b011;
    localparam logic [2:0] SEL_RO5  = 3'b010;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_NEXT_CH = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_COUNT   = 3'd3;
    localparam logic [2:0] ST_HOLD    = 3'd4;

    function automatic logic [2:0] ro_sel_code(input logic [2:0] ch);
        logic [2:0] code;
        case (ch)
            3'd0:    code = SEL_RO0;
            3'd1:    code = SEL_RO1;
            3'd2:    code = SEL_RO2;
            3'd3:    code = SEL_RO3;
            3'd4:    code = SEL_RO4;
            3'd5:    code = SEL_RO5;
            default: code = SEL_IDLE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ro_freq_counter_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge pulse generator for an
// input that is asynchronous to clk.
module ro_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic pulse
);

    logic meta_p0;
    logic sync_p1;
    logic sync_p2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            meta_p0 <= async_in;
            sync_p1 <= meta_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign pulse = sync_p1 & ~sync_p2;

endmodule

// File: rtl/ro_freq_counter.sv
// Scans the enabled ring oscillators, counts rising edges of the muxed RO
// output over a fixed window per channel and offers each count on a
// valid/ready port.
module ro_freq_counter
    import ro_sensor_defs::*;
#(
    parameter int CNT_W      = 16,
    parameter int WIN_CYC    = 1024,
    parameter int SETTLE_CYC = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [5:0]       CH_MASK,
    input  logic             RO_OUT,
    output logic [2:0]       S,
    output logic             BUSY,
    output logic             CNT_VALID,
    input  logic             CNT_READY,
    output logic [CNT_W-1:0] CNT_DATA,
    output logic [2:0]       CNT_CH,
    output logic             CNT_OVF,
    output logic             DONE
);

    localparam int CYC_MAX = (WIN_CYC > SETTLE_CYC) ? WIN_CYC : SETTLE_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX);

    logic [2:0]       state;
    logic [5:0]       pend_mask;
    logic [CYC_W-1:0] cyc_cnt;
    logic             edge_pulse;
    logic [3:0]       next_pick;
    logic [CNT_W:0]   cnt_inc;

    // Saturating increment; MSB of the result flags an attempted wrap.
    function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v)
            return {1'b1, v};
        else
            return {1'b0, v + 1'b1};
    endfunction

    // Lowest pending channel as {found, index}.
    function automatic logic [3:0] pick_lowest(input logic [5:0] m);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = NUM_RO - 1; i >= 0; i--)
            if (m[i]) r = {1'b1, 3'(i)};
        return r;
    endfunction

    ro_edge_sync u_edge_sync (
        .clk      (CLK),
        .rst      (RST),
        .async_in (RO_OUT),
        .pulse    (edge_pulse)
    );

    assign next_pick = pick_lowest(pend_mask);
    assign cnt_inc   = sat_inc(CNT_DATA);
    assign BUSY      = (state != ST_IDLE);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            pend_mask <= 6'b0;
            cyc_cnt   <= '0;
            S         <= SEL_IDLE;
            CNT_VALID <= 1'b0;
            CNT_DATA  <= '0;
            CNT_CH    <= 3'd0;
            CNT_OVF   <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (START) begin
                        pend_mask <= CH_MASK;
                        state     <= ST_NEXT_CH;
                    end
                end
                ST_NEXT_CH: begin
                    // Servicing a channel retires its mask bit, so the lowest
                    // remaining bit is always above the last channel served.
                    if (next_pick[3]) begin
                        S         <= ro_sel_code(next_pick[2:0]);
                        CNT_CH    <= next_pick[2:0];
                        pend_mask <= pend_mask & ~(6'b000001 << next_pick[2:0]);
                        CNT_DATA  <= '0;
                        CNT_OVF   <= 1'b0;
                        cyc_cnt   <= '0;
                        state     <= ST_SETTLE;
                    end else begin
                        S     <= SEL_IDLE;
                        DONE  <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    if (cyc_cnt == CYC_W'(SETTLE_CYC - 1)) begin
                        cyc_cnt <= '0;
                        state   <= ST_COUNT;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (edge_pulse) begin
                        CNT_DATA <= cnt_inc[CNT_W-1:0];
                        if (cnt_inc[CNT_W]) CNT_OVF <= 1'b1;
                    end
                    if (cyc_cnt == CYC_W'(WIN_CYC - 1)) begin
                        cyc_cnt   <= '0;
                        CNT_VALID <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (CNT_VALID && CNT_READY) begin
                        CNT_VALID <= 1'b0;
                        state     <= ST_NEXT_CH;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ro_freq_counter.sv
// Self-checking bench for ro_freq_counter: one instance with a short window
// for the scan scenarios and a narrow-count instance for saturation.
module tb_ro_freq_counter;

    typedef struct {
        logic [2:0] ch;
        logic [2:0] sel;
        int         cnt;
        logic       ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start_a = 1'b0;
    logic [5:0]  mask_a  = 6'b0;
    logic        ro_a;
    logic [2:0]  s_a;
    logic        busy_a, valid_a, ovf_a, done_a;
    logic        ready_a = 1'b1;
    logic [15:0] data_a;
    logic [2:0]  ch_a;

    logic        start_s = 1'b0;
    logic [5:0]  mask_s  = 6'b0;
    logic        ro_s;
    logic [2:0]  s_s;
    logic        busy_s, valid_s, ovf_s, done_s;
    logic        ready_s = 1'b1;
    logic [3:0]  data_s;
    logic [2:0]  ch_s;

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt_a = 0;
    int   ro_ctr = 0;
    int   ro_per [6] = '{8, 8, 8, 8, 8, 8};
    int   cur_per;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ro_freq_counter #(.CNT_W(16), .WIN_CYC(64), .SETTLE_CYC(4)) dut_a (
        .CLK(clk), .RST(rst), .START(start_a), .CH_MASK(mask_a), .RO_OUT(ro_a),
        .S(s_a), .BUSY(busy_a), .CNT_VALID(valid_a), .CNT_READY(ready_a),
        .CNT_DATA(data_a), .CNT_CH(ch_a), .CNT_OVF(ovf_a), .DONE(done_a)
    );

    ro_freq_counter #(.CNT_W(4), .WIN_CYC(128), .SETTLE_CYC(4)) dut_s (
        .CLK(clk), .RST(rst), .START(start_s), .CH_MASK(mask_s), .RO_OUT(ro_s),
        .S(s_s), .BUSY(busy_s), .CNT_VALID(valid_s), .CNT_READY(ready_s),
        .CNT_DATA(data_s), .CNT_CH(ch_s), .CNT_OVF(ovf_s), .DONE(done_s)
    );

    // RO stimulus: period chosen by the channel currently selected on dut_a.
    always @(negedge clk) ro_ctr <= ro_ctr + 1;

    always_comb begin
        cur_per = 8;
        if (s_a != 3'b000) cur_per = ro_per[3'(3'd7 - s_a)];
        ro_a = ((ro_ctr % cur_per) < (cur_per / 2));
        ro_s = ((ro_ctr % 4) < 2);
    end

    always @(negedge clk) if (done_a === 1'b1) done_cnt_a++;

    // Scoreboard: every completed handshake on dut_a pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (valid_a === 1'b1 && ready_a === 1'b1) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_result: ch=%0d data=%0d, no result expected", ch_a, data_a);
            end else begin
                e = sb_q.pop_front();
                if (ch_a !== e.ch || s_a !== e.sel || ovf_a !== e.ovf ||
                    int'(data_a) < e.cnt - 1 || int'(data_a) > e.cnt + 1) begin
                    n_err++;
                    $display("FAIL sb_result: got ch=%0d S=%b data=%0d ovf=%b, want ch=%0d S=%b data=%0d+-1 ovf=%b",
                             ch_a, s_a, data_a, ovf_a, e.ch, e.sel, e.cnt, e.ovf);
                end
            end
        end
    end

    task automatic push_exp(input int ch, input int cnt);
        exp_t e;
        e.ch  = 3'(ch);
        e.sel = 3'(7 - ch);
        e.cnt = cnt;
        e.ovf = 1'b0;
        sb_q.push_back(e);
    endtask

    task automatic pulse_start_a(input logic [5:0] m);
        @(negedge clk);
        mask_a  = m;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic wait_done_a(input int bound, input string name);
        int n;
        int d0;
        d0 = done_cnt_a;
        n  = 0;
        while (done_cnt_a == d0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done_cnt_a == d0) begin
            n_err++;
            $display("FAIL %s_done_timeout: no DONE within %0d cycles", name, bound);
        end
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({s_a, busy_a, valid_a, data_a, ch_a, ovf_a, done_a} !== 25'b0) begin
            n_err++;
            $display("FAIL reset_outputs: S=%b BUSY=%b VALID=%b DATA=%0d CH=%0d OVF=%b DONE=%b, want all 0",
                     s_a, busy_a, valid_a, data_a, ch_a, ovf_a, done_a);
        end
        n_cmp++;
        if ({s_s, busy_s, valid_s, data_s, ch_s, ovf_s, done_s} !== 13'b0) begin
            n_err++;
            $display("FAIL reset_outputs_sat: S=%b BUSY=%b VALID=%b DATA=%0d, want all 0",
                     s_s, busy_s, valid_s, data_s);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        int n;
        int d0;
        ready_a = 1'b1;
        push_exp(0, 8);
        d0 = done_cnt_a;
        pulse_start_a(6'b000001);
        n = 1;
        while (valid_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 70) begin
            n_err++;
            $display("FAIL single_latency: CNT_VALID at cycle %0d, want 70", n);
        end
        n_cmp++;
        if (s_a !== 3'b111) begin
            n_err++;
            $display("FAIL single_select: S=%b, want 111", s_a);
        end
        n_cmp++;
        if (done_cnt_a != d0) begin
            n_err++;
            $display("FAIL single_early_done: DONE count %0d before handshake, want %0d", done_cnt_a, d0);
        end
        wait_done_a(10, "single");
        @(negedge clk);
        n_cmp++;
        if (s_a !== 3'b000 || busy_a !== 1'b0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL single_end: S=%b BUSY=%b pending=%0d, want 000 0 0", s_a, busy_a, sb_q.size());
        end
    endtask

    task automatic test_full_scan();
        int d0;
        ro_per  = '{8, 8, 8, 4, 8, 16};
        ready_a = 1'b1;
        push_exp(1, 8);
        push_exp(3, 16);
        push_exp(5, 4);
        d0 = done_cnt_a;
        pulse_start_a(6'b101010);
        wait_done_a(400, "scan");
        repeat (5) @(negedge clk);
        n_cmp++;
        if (done_cnt_a - d0 != 1) begin
            n_err++;
            $display("FAIL scan_done_pulses: got %0d, want 1", done_cnt_a - d0);
        end
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scan_results: %0d results missing, want 0", sb_q.size());
        end
        ro_per = '{8, 8, 8, 8, 8, 8};
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        logic [15:0] rec_data;
        logic [2:0]  rec_ch;
        ready_a = 1'b0;
        push_exp(2, 8);
        pulse_start_a(6'b000100);
        n = 1;
        while (valid_a !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (valid_a !== 1'b1) begin
            n_err++;
            $display("FAIL bp_valid_timeout: CNT_VALID=%b after %0d cycles, want 1", valid_a, n);
        end
        rec_data = data_a;
        rec_ch   = ch_a;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            start_a = (i == 5 || i == 12);
            @(negedge clk);
            if (valid_a !== 1'b1 || data_a !== rec_data || ch_a !== rec_ch ||
                busy_a !== 1'b1 || s_a !== 3'b101)
                bad++;
        end
        start_a = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL bp_hold_stable: %0d unstable cycles (VALID=%b DATA=%0d CH=%0d BUSY=%b), want 0",
                     bad, valid_a, data_a, ch_a, busy_a);
        end
        ready_a = 1'b1;
        wait_done_a(10, "bp");
        repeat (4) @(negedge clk);
        n_cmp++;
        if (busy_a !== 1'b0 || sb_q.size() != 0) begin
            n_err++;
            $display("FAIL bp_end: BUSY=%b pending=%0d, want 0 0", busy_a, sb_q.size());
        end
    endtask

    task automatic test_saturation();
        int n;
        ready_s = 1'b1;
        @(negedge clk);
        mask_s  = 6'b000001;
        start_s = 1'b1;
        @(negedge clk);
        start_s = 1'b0;
        n = 1;
        while (valid_s !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n != 134) begin
            n_err++;
            $display("FAIL sat_latency: CNT_VALID at cycle %0d, want 134", n);
        end
        n_cmp++;
        if (data_s !== 4'd15 || ovf_s !== 1'b1 || ch_s !== 3'd0) begin
            n_err++;
            $display("FAIL sat_value: DATA=%0d OVF=%b CH=%0d, want 15 1 0", data_s, ovf_s, ch_s);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_empty_mask();
        int seen_valid;
        int seen_sel;
        pulse_start_a(6'b000000);
        n_cmp++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_err++;
            $display("FAIL empty_cycle1: DONE=%b BUSY=%b, want 0 1", done_a, busy_a);
        end
        @(negedge clk);
        n_cmp++;
        if (done_a !== 1'b1 || busy_a !== 1'b0) begin
            n_err++;
            $display("FAIL empty_cycle2: DONE=%b BUSY=%b, want 1 0", done_a, busy_a);
        end
        seen_valid = 0;
        seen_sel   = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (valid_a !== 1'b0) seen_valid++;
            if (s_a !== 3'b000) seen_sel++;
        end
        n_cmp++;
        if (seen_valid != 0 || seen_sel != 0 || done_a !== 1'b0) begin
            n_err++;
            $display("FAIL empty_idle: valid cycles=%0d nonzero S cycles=%0d DONE=%b, want 0 0 0",
                     seen_valid, seen_sel, done_a);
        end
    endtask

    task automatic test_reset_mid_count();
        int d0;
        ready_a = 1'b1;
        pulse_start_a(6'b000001);
        repeat (20) @(negedge clk);
        d0 = done_cnt_a;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (s_a !== 3'b000 || busy_a !== 1'b0 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_count: S=%b BUSY=%b VALID=%b, want 000 0 0", s_a, busy_a, valid_a);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        n_cmp++;
        if (done_cnt_a != d0 || valid_a !== 1'b0) begin
            n_err++;
            $display("FAIL rst_no_done: DONE pulses=%0d VALID=%b, want 0 0", done_cnt_a - d0, valid_a);
        end
        push_exp(0, 8);
        pulse_start_a(6'b000001);
        wait_done_a(200, "rst_restart");
        @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0 || done_cnt_a - d0 != 1) begin
            n_err++;
            $display("FAIL rst_restart: pending=%0d DONE pulses=%0d, want 0 1", sb_q.size(), done_cnt_a - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_scan();
        test_backpressure();
        test_saturation();
        test_empty_mask();
        test_reset_mid_count();
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ro_freq_counter.md
Name: ro_freq_counter

Overview:
- Downstream consumer of the 6:1 ring-oscillator select mux in the digital V/T sensor.
- Sequences through the enabled ROs and drives the mux select code S[3:1].
- For each RO: waits a settle time, then counts rising edges of the muxed RO output over a fixed CLK window.
- Presents each count on a valid/ready result port for the sensor readout logic.

Parameters:
- CNT_W, 16, result count width; count saturates at 2^CNT_W-1.
- WIN_CYC, 1024, counting window length in CLK cycles (>=2).
- SETTLE_CYC, 8, cycles S is held before counting starts (>=2, covers synchroniser flush).

Ports:
- CLK  input  1  sensor reference clock.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  single-cycle request to begin a scan; honoured only in IDLE.
- CH_MASK  input  6  per-RO enable; bit i enables RO i; sampled when START is accepted.
- RO_OUT  input  1  muxed ring-oscillator output; asynchronous to CLK.
- S  output  3  mux select S[3:1].
- BUSY  output  1  high whenever state != IDLE.
- CNT_VALID  output  1  result valid.
- CNT_READY  input  1  result accepted by consumer.
- CNT_DATA  output  CNT_W  rising-edge count for the current channel.
- CNT_CH  output  3  RO index (0..5) of CNT_DATA.
- CNT_OVF  output  1  count saturated during the window.
- DONE  output  1  one-cycle pulse when a scan finishes.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
- Reset values: state=IDLE, S=3'b000, BUSY=0, CNT_VALID=0, CNT_DATA=0, CNT_CH=0, CNT_OVF=0, DONE=0. Synchroniser flops cleared to 0.
- Select encoding {S3,S2,S1}: RO0=111, RO1=110, RO2=101, RO3=100, RO4=011, RO5=010. IDLE drives 000, which gives a mux output of constant 0.
- RO_OUT path: 2-FF synchroniser, then a rising-edge detector (sync2 & ~sync3). Runs continuously in all states.
- Frequency limit: RO_OUT frequency must be < CLK/2. Faster edges alias and are not detected.
- IDLE:
  - On START, latch CH_MASK and go to NEXT_CH.
  - START while BUSY is ignored.
- NEXT_CH (1 cycle):
  - Pick the lowest-index enabled channel greater than the last one serviced (the search starts from -1 at scan start).
  - If one exists: load S, set CNT_CH, go to SETTLE.
  - If none: go to IDLE and pulse DONE in that cycle.
  - Mask 000000: DONE asserts 2 cycles after START; no results are produced.
- SETTLE: hold S for SETTLE_CYC cycles with the counter cleared, then go to COUNT.
- COUNT:
  - Runs exactly WIN_CYC cycles.
  - Each cycle with an edge-detect pulse increments the counter.
  - At all-ones the counter holds and sets the overflow flag.
  - Edges detected outside COUNT are never counted.
- HOLD:
  - CNT_VALID=1; CNT_DATA, CNT_CH and CNT_OVF stay stable until CNT_VALID & CNT_READY.
  - CNT_READY may be held high in advance; the handshake completes on the first HOLD cycle.
  - After the handshake: CNT_VALID=0 next cycle, go to NEXT_CH.
  - S stays at the current channel's code during HOLD.
- Per-channel latency: 1 (NEXT_CH) + SETTLE_CYC + WIN_CYC cycles to CNT_VALID, plus the consumer stall.
- Reset mid-scan: immediate return to IDLE values. A partial count is discarded and no DONE pulse is produced.
- Simultaneous START and RST: reset wins.

Decomposition:
- Shared header/package ro_sensor_defs:
  - the six S select codes and the idle code;
  - the FSM state encoding (IDLE, NEXT_CH, SETTLE, COUNT, HOLD);
  - the RO count constant NUM_RO=6.
- One sub-module, ro_edge_sync: 2-FF synchroniser plus rising-edge pulse. The same block is reusable for other asynchronous sensor inputs.

Test Plan:
- Single channel: WIN_CYC=64, SETTLE_CYC=4, CH_MASK=000001, RO_OUT square wave with an 8-CLK period -> S=111; CNT_VALID at START+1+1+4+64; CNT_DATA=8 (tolerate 7–9 for an unaligned phase); CNT_CH=0; CNT_OVF=0; DONE after the handshake.
- Full scan: CH_MASK=101010 with a different period per RO, CNT_READY=1 -> three results in order CNT_CH=1,3,5 with S=110,100,010; counts = 64/period ±1; exactly one DONE pulse.
- Backpressure: CNT_READY=0 for 20 cycles in HOLD -> CNT_VALID stays high and CNT_DATA/CNT_CH stay constant; START pulses meanwhile are ignored and BUSY stays 1.
- Saturation: CNT_W=4, RO_OUT with a 4-CLK period, WIN_CYC=128 -> CNT_DATA=15, CNT_OVF=1.
- Empty mask and idle: CH_MASK=000000 -> DONE 2 cycles after START, no CNT_VALID, S stays 000.
- Async reset mid-COUNT: assert RST -> immediately S=000, BUSY=0, CNT_VALID=0; no DONE; a new START after release runs normally.
